mem_wb_pipe: RTL and testbench

Parametrised MEM→WB pipeline register, successor to the single-lane MEM/WB latch. Carries NUM_LANES register-file write lanes plus an optional HI/LO write. Adds a synchronous flush, r0 and same-destination write suppression, a combinational forwarding lookup on its registered contents, and saturating retire/bubble counters. It sits between the memory stage and the register file / HILO unit, and obeys the shared 6-bit pipeline control vector.

---
 rtl/mem_wb_pkg.sv | 36 +++
 rtl/mem_wb_pipe_sat_counter.sv | 42 ++++
 rtl/mem_wb_pipe.sv | 204 ++++++++++++++++++++
 tb/tb_mem_wb_pipe.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_wb_pkg.sv
// ============================================================================
// Module   : mem_wb_pkg
// Brief    : Shared pipeline-register definitions: control bit roles, action
//            enum and the action-decode function used by every stage register.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_wb_pkg;

  // Offsets relative to a stage's STAGE index inside the control vector.
  localparam int c_STALL_OFS  = 0;  // this stage is stalled
  localparam int c_DSTALL_OFS = 1;  // downstream stage is stalled

  typedef enum logic [1:0] {
    ACT_LOAD   = 2'd0,
    ACT_HOLD   = 2'd1,
    ACT_BUBBLE = 2'd2,
    ACT_FLUSH  = 2'd3
  } act_e;

  // Priority: flush > bubble > hold > load.
  function automatic act_e decode_action(input logic flush_i,
                                         input logic stall_i,
                                         input logic dstall_i);
    act_e act;
    if (flush_i)                 act = ACT_FLUSH;
    else if (stall_i && !dstall_i) act = ACT_BUBBLE;
    else if (stall_i)            act = ACT_HOLD;
    else                         act = ACT_LOAD;
    return act;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_wb_pipe_sat_counter.sv
// ============================================================================
// Module   : sat_counter
// Brief    : Accumulating counter that clamps at all-ones instead of wrapping.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sat_counter #(
  parameter int W     = 32,
  parameter int INC_W = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [INC_W-1:0] inc,
  output logic [W-1:0]     count_o
);

  // One extra headroom region wide enough to detect any overflow of a single add.
  localparam int c_SW = W + INC_W;

  logic [c_SW-1:0] w_sum;
  logic [W-1:0]    count_d;
  logic [W-1:0]    count_q;

  // Next value: add the increment, clamp to all-ones on overflow.
  always_comb begin
    w_sum   = c_SW'(count_q) + c_SW'(inc);
    count_d = w_sum[W-1:0];
    if (w_sum[c_SW-1:W] != '0) count_d = '1;
  end

  // Counter register with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/mem_wb_pipe.sv
// ============================================================================
// Module   : mem_wb_pipe
// Brief    : MEM->WB pipeline register with multi-lane regfile writes, HI/LO
//            write, flush/bubble/hold control, write suppression, forwarding
//            lookup and saturating retire/bubble counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_wb_pipe
  import mem_wb_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int REG_AW    = 5,
  parameter int NUM_LANES = 1,
  parameter int HILO_EN   = 1,
  parameter int CTRL_W    = 6,
  parameter int STAGE     = 4,
  parameter int CNT_W     = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [CTRL_W-1:0]           control,
  input  logic                        flush,
  input  logic [NUM_LANES-1:0]        in_valid,
  input  logic [NUM_LANES*REG_AW-1:0] in_dest,
  input  logic [NUM_LANES-1:0]        in_we,
  input  logic [NUM_LANES*DATA_W-1:0] in_wdata,
  input  logic                        in_hilo_we,
  input  logic [DATA_W-1:0]           in_hi,
  input  logic [DATA_W-1:0]           in_lo,
  output logic [NUM_LANES-1:0]        out_valid,
  output logic [NUM_LANES*REG_AW-1:0] out_dest,
  output logic [NUM_LANES-1:0]        out_we,
  output logic [NUM_LANES*DATA_W-1:0] out_wdata,
  output logic                        out_hilo_we,
  output logic [DATA_W-1:0]           out_hi,
  output logic [DATA_W-1:0]           out_lo,
  input  logic [REG_AW-1:0]           fwd_addr,
  output logic                        fwd_hit,
  output logic [DATA_W-1:0]           fwd_data,
  output logic [CNT_W-1:0]            retire_cnt,
  output logic [CNT_W-1:0]            bubble_cnt
);

  localparam int c_INC_W = $clog2(NUM_LANES + 1);

  act_e                        w_act;
  logic [NUM_LANES-1:0]        w_qual;
  logic [NUM_LANES-1:0]        w_we_capt;
  logic [c_INC_W-1:0]          w_pop;
  logic [c_INC_W-1:0]          w_retire_inc;
  logic                        w_bubble_inc;

  logic [NUM_LANES-1:0]        valid_d, valid_q;
  logic [NUM_LANES*REG_AW-1:0] dest_d,  dest_q;
  logic [NUM_LANES-1:0]        we_d,    we_q;
  logic [NUM_LANES*DATA_W-1:0] wdata_d, wdata_q;

  assign w_act = decode_action(flush,
                               control[STAGE + c_STALL_OFS],
                               control[STAGE + c_DSTALL_OFS]);

  // Qualify each lane's write; a later lane to the same register silences earlier ones.
  always_comb begin
    w_qual    = '0;
    w_we_capt = '0;
    w_pop     = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      w_qual[i] = in_we[i] & in_valid[i] & (in_dest[i*REG_AW +: REG_AW] != '0);
      w_pop     = w_pop + c_INC_W'(in_valid[i]);
    end
    for (int i = 0; i < NUM_LANES; i++) begin
      w_we_capt[i] = w_qual[i];
      for (int j = i + 1; j < NUM_LANES; j++) begin
        if (w_qual[j] && (in_dest[j*REG_AW +: REG_AW] == in_dest[i*REG_AW +: REG_AW]))
          w_we_capt[i] = 1'b0;
      end
    end
  end

  // Lane payload next-state selection by action.
  always_comb begin
    valid_d = valid_q;
    dest_d  = dest_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    case (w_act)
      ACT_LOAD: begin
        valid_d = in_valid;
        dest_d  = in_dest;
        we_d    = w_we_capt;
        wdata_d = in_wdata;
      end
      ACT_BUBBLE, ACT_FLUSH: begin
        valid_d = '0;
        dest_d  = '0;
        we_d    = '0;
        wdata_d = '0;
      end
      default: ;
    endcase
  end

  // Lane payload registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      dest_q  <= '0;
      we_q    <= '0;
      wdata_q <= '0;
    end else begin
      valid_q <= valid_d;
      dest_q  <= dest_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
    end
  end

  assign out_valid = valid_q;
  assign out_dest  = dest_q;
  assign out_we    = we_q;
  assign out_wdata = wdata_q;

  generate
    if (HILO_EN != 0) begin : g_hilo
      logic              hilo_we_d, hilo_we_q;
      logic [DATA_W-1:0] hi_d, hi_q, lo_d, lo_q;

      // HI/LO next-state; the write only counts when some lane is real.
      always_comb begin
        hilo_we_d = hilo_we_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        case (w_act)
          ACT_LOAD: begin
            hilo_we_d = in_hilo_we & (|in_valid);
            hi_d      = in_hi;
            lo_d      = in_lo;
          end
          ACT_BUBBLE, ACT_FLUSH: begin
            hilo_we_d = 1'b0;
            hi_d      = '0;
            lo_d      = '0;
          end
          default: ;
        endcase
      end

      // HI/LO registers.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          hilo_we_q <= 1'b0;
          hi_q      <= '0;
          lo_q      <= '0;
        end else begin
          hilo_we_q <= hilo_we_d;
          hi_q      <= hi_d;
          lo_q      <= lo_d;
        end
      end

      assign out_hilo_we = hilo_we_q;
      assign out_hi      = hi_q;
      assign out_lo      = lo_q;
    end else begin : g_no_hilo
      assign out_hilo_we = 1'b0;
      assign out_hi      = '0;
      assign out_lo      = '0;
    end
  endgenerate

  // Forwarding lookup on registered lanes only; highest matching lane wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if ((fwd_addr != '0) && we_q[i] && (dest_q[i*REG_AW +: REG_AW] == fwd_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = wdata_q[i*DATA_W +: DATA_W];
      end
    end
  end

  assign w_retire_inc = (w_act == ACT_LOAD) ? w_pop : '0;
  assign w_bubble_inc = (w_act == ACT_BUBBLE) || (w_act == ACT_FLUSH);

  sat_counter #(.W(CNT_W), .INC_W(c_INC_W)) u_retire_cnt (
    .clk     (clk),
    .rst     (rst),
    .inc     (w_retire_inc),
    .count_o (retire_cnt)
  );

  sat_counter #(.W(CNT_W), .INC_W(1)) u_bubble_cnt (
    .clk     (clk),
    .rst     (rst),
    .inc     (w_bubble_inc),
    .count_o (bubble_cnt)
  );

endmodule

`default_nettype wire

// File: tb/tb_mem_wb_pipe.sv
// ============================================================================
// Module   : tb_mem_wb_pipe
// Brief    : Self-checking bench for mem_wb_pipe (2 lanes, 32-bit and 4-bit
//            counter instances driven by the same stimulus).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_wb_pipe;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NL = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [5:0]      control;
  logic            flush;
  logic [NL-1:0]   in_valid, in_we;
  logic [NL*AW-1:0] in_dest;
  logic [NL*DW-1:0] in_wdata;
  logic            in_hilo_we;
  logic [DW-1:0]   in_hi, in_lo;
  logic [AW-1:0]   fwd_addr;

  logic [NL-1:0]   out_valid, out_we;
  logic [NL*AW-1:0] out_dest;
  logic [NL*DW-1:0] out_wdata;
  logic            out_hilo_we;
  logic [DW-1:0]   out_hi, out_lo, fwd_data;
  logic            fwd_hit;
  logic [31:0]     retire_cnt, bubble_cnt;

  logic [NL-1:0]   s_valid, s_we;
  logic [NL*AW-1:0] s_dest;
  logic [NL*DW-1:0] s_wdata;
  logic            s_hilo_we, s_fwd_hit;
  logic [DW-1:0]   s_hi, s_lo, s_fwd_data;
  logic [3:0]      s_retire_cnt, s_bubble_cnt;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [NL-1:0]    e_valid, e_we;
  logic [NL*AW-1:0] e_dest;
  logic [NL*DW-1:0] e_wdata;
  logic             e_hilo_we;
  logic [DW-1:0]    e_hi, e_lo;
  longint           e_ret, e_bub, e_ret4, e_bub4;

  always #5 clk = ~clk;

  mem_wb_pipe #(.DATA_W(DW), .REG_AW(AW), .NUM_LANES(NL), .HILO_EN(1),
                .CTRL_W(6), .STAGE(4), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .control(control), .flush(flush),
    .in_valid(in_valid), .in_dest(in_dest), .in_we(in_we), .in_wdata(in_wdata),
    .in_hilo_we(in_hilo_we), .in_hi(in_hi), .in_lo(in_lo),
    .out_valid(out_valid), .out_dest(out_dest), .out_we(out_we), .out_wdata(out_wdata),
    .out_hilo_we(out_hilo_we), .out_hi(out_hi), .out_lo(out_lo),
    .fwd_addr(fwd_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
    .retire_cnt(retire_cnt), .bubble_cnt(bubble_cnt)
  );

  mem_wb_pipe #(.DATA_W(DW), .REG_AW(AW), .NUM_LANES(NL), .HILO_EN(1),
                .CTRL_W(6), .STAGE(4), .CNT_W(4)) dut_small (
    .clk(clk), .rst(rst), .control(control), .flush(flush),
    .in_valid(in_valid), .in_dest(in_dest), .in_we(in_we), .in_wdata(in_wdata),
    .in_hilo_we(in_hilo_we), .in_hi(in_hi), .in_lo(in_lo),
    .out_valid(s_valid), .out_dest(s_dest), .out_we(s_we), .out_wdata(s_wdata),
    .out_hilo_we(s_hilo_we), .out_hi(s_hi), .out_lo(s_lo),
    .fwd_addr(fwd_addr), .fwd_hit(s_fwd_hit), .fwd_data(s_fwd_data),
    .retire_cnt(s_retire_cnt), .bubble_cnt(s_bubble_cnt)
  );

  function automatic longint sat_add(input longint a, input longint b, input longint mx);
    return (a + b > mx) ? mx : a + b;
  endfunction

  task automatic model_reset();
    e_valid = '0; e_we = '0; e_dest = '0; e_wdata = '0;
    e_hilo_we = 1'b0; e_hi = '0; e_lo = '0;
    e_ret = 0; e_bub = 0; e_ret4 = 0; e_bub4 = 0;
  endtask

  task automatic model_clear();
    e_valid = '0; e_we = '0; e_dest = '0; e_wdata = '0;
    e_hilo_we = 1'b0; e_hi = '0; e_lo = '0;
    e_bub  = sat_add(e_bub, 1, 64'hFFFF_FFFF);
    e_bub4 = sat_add(e_bub4, 1, 15);
  endtask

  // Apply the stage rules for the inputs currently driven.
  task automatic model_edge();
    bit q[NL];
    int pop;
    if (flush) model_clear();
    else if (control[4] && !control[5]) model_clear();
    else if (control[4]) begin end
    else begin
      pop = 0;
      for (int i = 0; i < NL; i++) begin
        q[i] = in_we[i] && in_valid[i] && (in_dest[i*AW +: AW] != 0);
        pop += int'(in_valid[i]);
      end
      for (int i = 0; i < NL; i++) begin
        e_we[i] = q[i];
        for (int j = i + 1; j < NL; j++)
          if (q[j] && in_dest[j*AW +: AW] == in_dest[i*AW +: AW]) e_we[i] = 1'b0;
      end
      e_valid = in_valid; e_dest = in_dest; e_wdata = in_wdata;
      e_hilo_we = in_hilo_we && (in_valid != 0);
      e_hi = in_hi; e_lo = in_lo;
      e_ret  = sat_add(e_ret, pop, 64'hFFFF_FFFF);
      e_ret4 = sat_add(e_ret4, pop, 15);
    end
  endtask

  function automatic logic [DW:0] fwd_model(input logic [AW-1:0] a);
    for (int i = NL - 1; i >= 0; i--)
      if (a != 0 && e_we[i] && e_dest[i*AW +: AW] == a) return {1'b1, e_wdata[i*DW +: DW]};
    return '0;
  endfunction

  // Inputs are already driven; advance one edge and settle.
  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    control = '0; flush = 0; in_valid = '0; in_we = '0; in_dest = '0;
    in_wdata = '0; in_hilo_we = 0; in_hi = '0; in_lo = '0; fwd_addr = '0;
  endtask

  task automatic do_reset();
    drive_idle();
    rst = 1'b1;
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    in_valid = 2'b11; in_we = 2'b11; in_dest = {5'd3, 5'd2};
    in_wdata = {32'h1111_2222, 32'h3333_4444}; in_hilo_we = 1; in_hi = 32'hAA; in_lo = 32'hBB;
    step();
    checks++;
    if (out_valid !== 2'b11 || retire_cnt !== 32'd2) begin
      errors++;
      $display("FAIL reset_preload: valid=%b ret=%0d want valid=11 ret=2", out_valid, retire_cnt);
    end
    #3 rst = 1'b1;
    #1;
    model_reset();
    checks++;
    if ({out_valid, out_we, out_dest, out_wdata, out_hilo_we, out_hi, out_lo, fwd_hit, fwd_data,
         retire_cnt, bubble_cnt, s_retire_cnt, s_bubble_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_async: valid=%b we=%b wdata=%h hi=%h ret=%0d bub=%0d want all zero",
               out_valid, out_we, out_wdata, out_hi, retire_cnt, bubble_cnt);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    drive_idle();
  endtask

  task automatic test_load();
    in_valid = 2'b11; in_we = 2'b11; in_dest = {5'd7, 5'd5};
    in_wdata = {32'hBBBB_0002, 32'hAAAA_0001}; in_hilo_we = 1; in_hi = 32'h1234; in_lo = 32'h5678;
    step();
    fwd_addr = 5'd7; #1;
    checks++;
    if (out_we !== 2'b11 || retire_cnt !== 32'd2) begin
      errors++;
      $display("FAIL load_we: we=%b ret=%0d want we=11 ret=2", out_we, retire_cnt);
    end
    checks++;
    if (fwd_hit !== 1'b1 || fwd_data !== 32'hBBBB_0002) begin
      errors++;
      $display("FAIL load_fwd: hit=%b data=%h want hit=1 data=bbbb0002", fwd_hit, fwd_data);
    end
    checks++;
    if (out_hilo_we !== 1'b1 || out_hi !== 32'h1234 || out_lo !== 32'h5678) begin
      errors++;
      $display("FAIL load_hilo: we=%b hi=%h lo=%h want 1 1234 5678", out_hilo_we, out_hi, out_lo);
    end
  endtask

  task automatic test_collision();
    in_valid = 2'b11; in_we = 2'b11; in_dest = {5'd9, 5'd9};
    in_wdata = {32'hC0DE_0001, 32'hC0DE_0000};
    step();
    fwd_addr = 5'd9; #1;
    checks++;
    if (out_we !== 2'b10 || fwd_hit !== 1'b1 || fwd_data !== 32'hC0DE_0001) begin
      errors++;
      $display("FAIL collision: we=%b hit=%b data=%h want 10 1 c0de0001", out_we, fwd_hit, fwd_data);
    end
    in_dest = {5'd0, 5'd0};
    step();
    fwd_addr = 5'd0; #1;
    checks++;
    if (out_we !== 2'b00 || fwd_hit !== 1'b0 || fwd_data !== '0) begin
      errors++;
      $display("FAIL dest_zero: we=%b hit=%b data=%h want 00 0 0", out_we, fwd_hit, fwd_data);
    end
  endtask

  task automatic test_control();
    in_valid = 2'b01; in_we = 2'b01; in_dest = {5'd4, 5'd12};
    in_wdata = {32'h0, 32'hFEED_BEEF}; in_hilo_we = 0;
    step();
    in_valid = 2'b11; in_dest = {5'd1, 5'd2}; in_wdata = {32'h9, 32'h8}; in_hilo_we = 1;
    control = 6'b11_0000;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if (out_valid !== 2'b01 || out_dest !== {5'd4, 5'd12} || out_wdata !== {32'h0, 32'hFEED_BEEF}
          || out_we !== 2'b01 || retire_cnt !== e_ret[31:0] || bubble_cnt !== e_bub[31:0]) begin
        errors++;
        $display("FAIL hold_%0d: valid=%b dest=%h wdata=%h ret=%0d bub=%0d want 01 %h %h %0d %0d",
                 k, out_valid, out_dest, out_wdata, retire_cnt, bubble_cnt,
                 {5'd4, 5'd12}, {32'h0, 32'hFEED_BEEF}, e_ret, e_bub);
      end
    end
    control = 6'b01_0000;
    step();
    checks++;
    if ({out_valid, out_we, out_dest, out_wdata, out_hilo_we} !== '0 || bubble_cnt !== e_bub[31:0]) begin
      errors++;
      $display("FAIL bubble: valid=%b wdata=%h bub=%0d want 0 0 %0d", out_valid, out_wdata, bubble_cnt, e_bub);
    end
    control = '0;
  endtask

  task automatic test_flush();
    longint r0, b0;
    in_valid = 2'b11; in_we = 2'b11; in_dest = {5'd3, 5'd6}; in_wdata = {32'h77, 32'h66};
    step();
    r0 = e_ret; b0 = e_bub;
    flush = 1;
    step();
    checks++;
    if ({out_valid, out_we, out_wdata} !== '0 || retire_cnt !== r0[31:0] || bubble_cnt !== b0[31:0] + 32'd1) begin
      errors++;
      $display("FAIL flush_load: valid=%b ret=%0d bub=%0d want 0 %0d %0d", out_valid, retire_cnt, bubble_cnt, r0, b0 + 1);
    end
    control = 6'b11_0000;
    step();
    checks++;
    if (out_valid !== '0 || bubble_cnt !== b0[31:0] + 32'd2) begin
      errors++;
      $display("FAIL flush_hold: valid=%b bub=%0d want 0 %0d", out_valid, bubble_cnt, b0 + 2);
    end
    flush = 0; control = '0;
  endtask

  task automatic test_random();
    logic [DW:0] f;
    for (int n = 0; n < 300; n++) begin
      control    = 6'($urandom_range(0, 3)) << 4;
      flush      = ($urandom_range(0, 9) == 0);
      in_valid   = 2'($urandom);
      in_we      = 2'($urandom);
      in_dest    = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
      in_wdata   = {32'($urandom), 32'($urandom)};
      in_hilo_we = 1'($urandom);
      in_hi      = 32'($urandom);
      in_lo      = 32'($urandom);
      step();
      fwd_addr = 5'($urandom_range(0, 4));
      #1;
      f = fwd_model(fwd_addr);
      checks++;
      if ({out_valid, out_we, out_dest, out_wdata} !== {e_valid, e_we, e_dest, e_wdata}) begin
        errors++;
        $display("FAIL rand_lanes[%0d]: v=%b we=%b d=%h wd=%h want v=%b we=%b d=%h wd=%h",
                 n, out_valid, out_we, out_dest, out_wdata, e_valid, e_we, e_dest, e_wdata);
      end
      checks++;
      if ({out_hilo_we, out_hi, out_lo} !== {e_hilo_we, e_hi, e_lo}) begin
        errors++;
        $display("FAIL rand_hilo[%0d]: we=%b hi=%h lo=%h want %b %h %h", n, out_hilo_we, out_hi, out_lo, e_hilo_we, e_hi, e_lo);
      end
      checks++;
      if ({fwd_hit, fwd_data} !== f) begin
        errors++;
        $display("FAIL rand_fwd[%0d]: addr=%0d hit=%b data=%h want %b %h", n, fwd_addr, fwd_hit, fwd_data, f[DW], f[DW-1:0]);
      end
      checks++;
      if (retire_cnt !== e_ret[31:0] || bubble_cnt !== e_bub[31:0] ||
          s_retire_cnt !== e_ret4[3:0] || s_bubble_cnt !== e_bub4[3:0]) begin
        errors++;
        $display("FAIL rand_cnt[%0d]: ret=%0d bub=%0d sret=%0d sbub=%0d want %0d %0d %0d %0d",
                 n, retire_cnt, bubble_cnt, s_retire_cnt, s_bubble_cnt, e_ret, e_bub, e_ret4, e_bub4);
      end
    end
    drive_idle();
  endtask

  task automatic test_saturation();
    do_reset();
    in_valid = 2'b11; in_we = 2'b11; in_dest = {5'd2, 5'd1}; in_wdata = {32'h2, 32'h1};
    for (int k = 0; k < 10; k++) step();
    checks++;
    if (s_retire_cnt !== 4'd15 || retire_cnt !== 32'd20) begin
      errors++;
      $display("FAIL sat_reach: sret=%0d ret=%0d want 15 20", s_retire_cnt, retire_cnt);
    end
    for (int k = 0; k < 3; k++) step();
    checks++;
    if (s_retire_cnt !== 4'd15 || retire_cnt !== 32'd26) begin
      errors++;
      $display("FAIL sat_stay: sret=%0d ret=%0d want 15 26", s_retire_cnt, retire_cnt);
    end
    control = 6'b01_0000;
    for (int k = 0; k < 17; k++) step();
    checks++;
    if (s_bubble_cnt !== 4'd15 || bubble_cnt !== 32'd17) begin
      errors++;
      $display("FAIL sat_bubble: sbub=%0d bub=%0d want 15 17", s_bubble_cnt, bubble_cnt);
    end
    drive_idle();
  endtask

  initial begin
    rst = 1'b1;
    drive_idle();
    model_reset();
    #12;
    test_reset();
    test_load();
    test_collision();
    test_control();
    test_flush();
    test_random();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
